// File: rtl/baccarat_settle.sv
// rtl/baccarat_settle.sv - per-seat wager acceptance and saturating round settlement
module baccarat_settle #(
   parameter int NUM_SEATS    = 4,
   parameter int BAL_WIDTH    = 8,
   parameter int WAGER_WIDTH  = 8,
   parameter int INIT_BALANCE = 100,
   parameter int TIE_MULT     = 8,
   parameter int PUSH_ON_TIE  = 0,
   localparam int SEAT_W      = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1
) (
   input  logic                   slow_clock,
   input  logic                   resetb,
   input  logic                   place_bet,
   input  logic [SEAT_W-1:0]      place_seat,
   input  logic [1:0]             place_side,
   input  logic [WAGER_WIDTH-1:0] place_amount,
   output logic                   place_ack,
   output logic                   place_reject,
   input  logic                   result_valid,
   input  logic [1:0]             result,
   output logic                   busy,
   output logic                   settle_done,
   input  logic [SEAT_W-1:0]      seat_sel,
   output logic [BAL_WIDTH-1:0]   balance_out,
   output logic [WAGER_WIDTH-1:0] wager_out,
   output logic [NUM_SEATS-1:0]   broke
);

   localparam int EXT_W = BAL_WIDTH + $clog2(TIE_MULT) + 1;
   localparam logic [EXT_W-1:0]     BAL_MAX  = EXT_W'({BAL_WIDTH{1'b1}});
   localparam logic [SEAT_W:0]      SEAT_CNT = (SEAT_W+1)'(NUM_SEATS);
   localparam logic [SEAT_W-1:0]    LAST_IDX = SEAT_W'(NUM_SEATS - 1);
   localparam logic [BAL_WIDTH-1:0] INIT_BAL = BAL_WIDTH'(INIT_BALANCE);
   localparam logic [1:0]           SIDE_TIE = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

   state_t                 state_q, state_d;
   logic [BAL_WIDTH-1:0]   bal_q   [NUM_SEATS];
   logic [BAL_WIDTH-1:0]   bal_d   [NUM_SEATS];
   logic [WAGER_WIDTH-1:0] wager_q [NUM_SEATS];
   logic [WAGER_WIDTH-1:0] wager_d [NUM_SEATS];
   logic [1:0]             side_q  [NUM_SEATS];
   logic [1:0]             side_d  [NUM_SEATS];
   logic [SEAT_W-1:0]      idx_q, idx_d;
   logic [1:0]             result_q, result_d;
   logic                   ack_q, ack_d, rej_q, rej_d;

   logic                   res_start, bet_ok;
   logic [BAL_WIDTH-1:0]   pbal, cbal, settled_bal;
   logic [WAGER_WIDTH-1:0] pwag, cwag;
   logic [1:0]             cside;
   logic [EXT_W-1:0]       ext_bal, ext_wag, settle_ext;

   assign res_start = (state_q == ST_IDLE) && result_valid && (result != 2'b00);

   // Lookups by loop so an out-of-range seat index never addresses the arrays.
   always_comb begin
      pbal  = '0;
      pwag  = '0;
      cbal  = '0;
      cwag  = '0;
      cside = 2'b00;
      for (int i = 0; i < NUM_SEATS; i++) begin
         if (place_seat == SEAT_W'(i)) begin
            pbal = bal_q[i];
            pwag = wager_q[i];
         end
         if (idx_q == SEAT_W'(i)) begin
            cbal  = bal_q[i];
            cwag  = wager_q[i];
            cside = side_q[i];
         end
      end
   end

   assign bet_ok = place_bet && (state_q == ST_IDLE) && !res_start
                   && ({1'b0, place_seat} < SEAT_CNT)
                   && (place_side != 2'b00) && (place_amount != '0)
                   && (BAL_WIDTH'(place_amount) <= pbal) && (pwag == '0);

   // A tie result against a non-tie side reaches the push branch only when side != result.
   always_comb begin
      ext_bal = EXT_W'(cbal);
      ext_wag = EXT_W'(cwag);
      if (cwag == '0)
         settle_ext = ext_bal;
      else if (cside == result_q)
         settle_ext = (cside == SIDE_TIE) ? ext_bal + ext_wag * EXT_W'(TIE_MULT)
                                          : ext_bal + ext_wag;
      else if ((PUSH_ON_TIE != 0) && (result_q == SIDE_TIE))
         settle_ext = ext_bal;
      else
         settle_ext = ext_bal - ext_wag;
      settled_bal = (settle_ext > BAL_MAX) ? BAL_MAX[BAL_WIDTH-1:0]
                                           : settle_ext[BAL_WIDTH-1:0];
   end

   always_comb begin
      bal_d    = bal_q;
      wager_d  = wager_q;
      side_d   = side_q;
      idx_d    = idx_q;
      result_d = result_q;
      ack_d    = place_bet && bet_ok;
      rej_d    = place_bet && !bet_ok;
      for (int i = 0; i < NUM_SEATS; i++) begin
         if (bet_ok && (place_seat == SEAT_W'(i))) begin
            wager_d[i] = place_amount;
            side_d[i]  = place_side;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (res_start) begin
               result_d = result;
               idx_d    = '0;
            end
         end
         ST_SETTLE: begin
            for (int i = 0; i < NUM_SEATS; i++) begin
               if (idx_q == SEAT_W'(i)) bal_d[i] = settled_bal;
            end
            idx_d = idx_q + SEAT_W'(1);
         end
         ST_DONE: begin
            for (int i = 0; i < NUM_SEATS; i++) begin
               wager_d[i] = '0;
               side_d[i]  = 2'b00;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (res_start) state_d = ST_SETTLE;
         ST_SETTLE: if (idx_q == LAST_IDX) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge slow_clock) begin
      if (!resetb) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         for (int i = 0; i < NUM_SEATS; i++) begin
            bal_q[i]   <= INIT_BAL;
            wager_q[i] <= '0;
            side_q[i]  <= 2'b00;
         end
         idx_q    <= '0;
         result_q <= 2'b00;
         ack_q    <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         bal_q    <= bal_d;
         wager_q  <= wager_d;
         side_q   <= side_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         ack_q    <= ack_d;
         rej_q    <= rej_d;
      end
   end

   always_comb begin
      balance_out = '0;
      wager_out   = '0;
      for (int i = 0; i < NUM_SEATS; i++) begin
         broke[i] = (bal_q[i] == '0);
         if (seat_sel == SEAT_W'(i)) begin
            balance_out = bal_q[i];
            wager_out   = wager_q[i];
         end
      end
   end

   assign place_ack    = ack_q;
   assign place_reject = rej_q;
   assign busy         = (state_q != ST_IDLE);
   assign settle_done  = (state_q == ST_DONE);

endmodule
